// File: rtl/csa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_pkg: shared helpers for csa_addsub_pipe (config check, sat values)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package csa_pkg;

  localparam int unsigned CSA_MAXW = 1024;

  function automatic bit csa_cfg_ok(input int unsigned width, input int unsigned block);
    if (block < 1) return 1'b0;
    if (width > CSA_MAXW || width < block) return 1'b0;
    return (width % block) == 0;
  endfunction

  // Largest positive two's-complement value of the given width.
  function automatic logic [CSA_MAXW-1:0] SAT_POS(input int unsigned width);
    logic [CSA_MAXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i + 1 < width; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [CSA_MAXW-1:0] SAT_NEG(input int unsigned width);
    logic [CSA_MAXW-1:0] r;
    r = '0;
    if (width >= 1 && width <= CSA_MAXW) r[width-1] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_block.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_block: BLOCK-wide ripple pair, carry-in 0 and carry-in 1 variants    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module csa_block
  import csa_pkg::*;
#(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  output logic [BLOCK-1:0] sum0_o,
  output logic [BLOCK-1:0] sum1_o,
  output logic             c0_o,
  output logic             c1_o
);

  logic w_k0;
  logic w_k1;

  always_comb begin
    w_k0   = 1'b0;
    w_k1   = 1'b1;
    sum0_o = '0;
    sum1_o = '0;
    for (int i = 0; i < BLOCK; i++) begin
      sum0_o[i] = a_i[i] ^ b_i[i] ^ w_k0;
      sum1_o[i] = a_i[i] ^ b_i[i] ^ w_k1;
      w_k0      = (a_i[i] & b_i[i]) | (w_k0 & (a_i[i] ^ b_i[i]));
      w_k1      = (a_i[i] & b_i[i]) | (w_k1 & (a_i[i] ^ b_i[i]));
    end
    c0_o = w_k0;
    c1_o = w_k1;
  end

endmodule
`default_nettype wire

// File: rtl/csa_addsub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_addsub_pipe: 2-stage carry-select add/sub, valid/ready, flags.       |
// | Define CSA_SAT_EN for a saturating sum on signed overflow.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module csa_addsub_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int MSB  = WIDTH - 1;

  if (!csa_cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
    $error("csa_addsub_pipe: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic                        w_load_a, w_load_b, w_take;
  logic [WIDTH-1:0]            w_b_eff;
  logic                        w_cin0;
  logic [NBLK-1:0][BLOCK-1:0]  w_s0, w_s1;
  logic [NBLK-1:0]             w_c0, w_c1;

  logic [NBLK-1:0][BLOCK-1:0]  s0_d, s1_d, s0_q, s1_q;
  logic [NBLK-1:0]             c0_d, c1_d, c0_q, c1_q;
  logic                        valid_a_q, a_msb_q, beff_msb_q;

  logic [WIDTH-1:0]            w_sum_raw, w_sum_fin;
  logic                        w_carry, w_ovf;
  logic [WIDTH-1:0]            sum_q;
  logic                        out_valid_q, cout_q, ovf_q, zero_q;

  // in_ready depends combinationally on out_ready; there is no skid buffer.
  assign w_load_b = !out_valid_q || out_ready;
  assign w_load_a = !valid_a_q || w_load_b;
  assign w_take   = in_valid && w_load_a;
  assign in_ready = w_load_a;

  assign w_b_eff = sub ? ~b : b;
  assign w_cin0  = cin ^ sub;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    csa_block #(.BLOCK(BLOCK)) u_blk (
      .a_i    (a[k*BLOCK +: BLOCK]),
      .b_i    (w_b_eff[k*BLOCK +: BLOCK]),
      .sum0_o (w_s0[k]),
      .sum1_o (w_s1[k]),
      .c0_o   (w_c0[k]),
      .c1_o   (w_c1[k])
    );
  end

  // Block 0 is resolved here; both halves of its pair hold the same value so
  // stage B can select uniformly across all blocks.
  always_comb begin
    s0_d    = w_s0;
    s1_d    = w_s1;
    c0_d    = w_c0;
    c1_d    = w_c1;
    s0_d[0] = w_cin0 ? w_s1[0] : w_s0[0];
    s1_d[0] = s0_d[0];
    c0_d[0] = w_cin0 ? w_c1[0] : w_c0[0];
    c1_d[0] = c0_d[0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_a_q  <= 1'b0;
      s0_q       <= '0;
      s1_q       <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
      a_msb_q    <= 1'b0;
      beff_msb_q <= 1'b0;
    end else begin
      if (w_load_a) valid_a_q <= in_valid;
      if (w_take) begin
        s0_q       <= s0_d;
        s1_q       <= s1_d;
        c0_q       <= c0_d;
        c1_q       <= c1_d;
        a_msb_q    <= a[MSB];
        beff_msb_q <= w_b_eff[MSB];
      end
    end
  end

  always_comb begin
    w_carry   = 1'b0;
    w_sum_raw = '0;
    for (int k = 0; k < NBLK; k++) begin
      w_sum_raw[k*BLOCK +: BLOCK] = w_carry ? s1_q[k] : s0_q[k];
      w_carry                     = w_carry ? c1_q[k] : c0_q[k];
    end
  end

  assign w_ovf = (a_msb_q == beff_msb_q) && (w_sum_raw[MSB] != a_msb_q);

`ifdef CSA_SAT_EN
  localparam logic [WIDTH-1:0] C_SAT_POS = WIDTH'(SAT_POS(WIDTH));
  localparam logic [WIDTH-1:0] C_SAT_NEG = WIDTH'(SAT_NEG(WIDTH));
  assign w_sum_fin = w_ovf ? (a_msb_q ? C_SAT_NEG : C_SAT_POS) : w_sum_raw;
`else
  assign w_sum_fin = w_sum_raw;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (w_load_b) begin
      out_valid_q <= valid_a_q;
      if (valid_a_q) begin
        sum_q  <= w_sum_fin;
        cout_q <= w_carry;
        ovf_q  <= w_ovf;
        zero_q <= (w_sum_fin == '0);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire
